lives_hud_ctrl: RTL and testbench



---
 rtl/lives_hud_ctrl_pkg.sv | 25 ++
 rtl/lives_hud_ctrl_rise_edge_det.sv | 22 ++
 rtl/lives_hud_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lives_hud_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lives_hud_ctrl_pkg.sv
// Shared types and constants for the lives HUD controller.
package lives_hud_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } lives_state_t;

    localparam int TILE_BITS = 5;
    localparam int TILE_SIZE = 32;
    localparam int LIVES_W   = 3;
    localparam int TIMER_W   = 8;

    // Increment that sticks at the given ceiling.
    function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v,
                                                   input logic [LIVES_W-1:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 3'd1;
        end
    endfunction

endpackage

// File: rtl/lives_hud_ctrl_rise_edge_det.sv
// Registered rising-edge detector: a held level yields exactly one event.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/lives_hud_ctrl.sv
// Lives counter, invulnerability/game-over FSM and heart-row hit test.
// Optional blinking during invulnerability is enabled by defining LIVES_BLINK_EN.
module lives_hud_ctrl
    import lives_hud_pkg::*;
#(
    parameter int TOP_LEFT_X        = 16,
    parameter int TOP_LEFT_Y        = 8,
    parameter int INIT_LIVES        = 3,
    parameter int MAX_LIVES         = 5,
    parameter int INVUL_FRAMES      = 120,
    parameter int BLINK_HALF_FRAMES = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic [10:0]  pixelX,
    input  logic [10:0]  pixelY,
    input  logic         startOfFrame,
    input  logic         hit,
    input  logic         extraLife,
    input  logic         newGame,
    output logic         InsideRectangle,
    output logic [10:0]  offsetX,
    output logic [10:0]  offsetY,
    output logic [2:0]   livesCount,
    output logic         gameOver
);

    localparam logic [LIVES_W-1:0] INIT_L     = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] MAX_L      = LIVES_W'(MAX_LIVES);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(INVUL_FRAMES);
    localparam logic [11:0]        TLX12      = 12'(TOP_LEFT_X);
    localparam logic [11:0]        TLY12      = 12'(TOP_LEFT_Y);
    localparam logic [11:0]        TILE12     = 12'(TILE_SIZE);

    lives_state_t         state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 game_over_q;
    logic                 inside_q, inside_d;
    logic [10:0]          offx_q, offx_d, offy_q, offy_d;
    logic                 hit_ev_s, xl_ev_s;
    logic [11:0]          x12_s, y12_s, right_x_s;

`ifdef LIVES_BLINK_EN
    localparam int BLINK_LOG2 = $clog2(BLINK_HALF_FRAMES);
    logic [BLINK_LOG2:0]  blink_q, blink_d;
`endif

    rise_edge_det u_hit_edge (.clk(clk), .rst_n(resetN), .d_i(hit),       .rise_o(hit_ev_s));
    rise_edge_det u_xl_edge  (.clk(clk), .rst_n(resetN), .d_i(extraLife), .rise_o(xl_ev_s));

    // Next-state logic for the life/invulnerability FSM.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        timer_d = timer_q;
`ifdef LIVES_BLINK_EN
        blink_d = blink_q;
`endif
        if (newGame) begin
            state_d = ALIVE;
            lives_d = INIT_L;
            timer_d = 8'd0;
`ifdef LIVES_BLINK_EN
            blink_d = '0;
`endif
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit_ev_s && xl_ev_s) begin
                        state_d = INVULN;
                        timer_d = TIMER_INIT;
`ifdef LIVES_BLINK_EN
                        blink_d = '0;
`endif
                    end else if (hit_ev_s) begin
                        if (lives_q > 3'd1) begin
                            lives_d = lives_q - 3'd1;
                            state_d = INVULN;
                            timer_d = TIMER_INIT;
`ifdef LIVES_BLINK_EN
                            blink_d = '0;
`endif
                        end else begin
                            lives_d = 3'd0;
                            state_d = DEAD;
                        end
                    end else if (xl_ev_s) begin
                        lives_d = sat_inc(lives_q, MAX_L);
                    end else begin
                        state_d = ALIVE;
                    end
                end
                INVULN: begin
                    if (xl_ev_s) begin
                        lives_d = sat_inc(lives_q, MAX_L);
                    end else begin
                        lives_d = lives_q;
                    end
                    // Timer of 0 here can only come from a corrupted state; recover to ALIVE.
                    if (timer_q == 8'd0) begin
                        state_d = ALIVE;
                    end else if (startOfFrame) begin
                        timer_d = timer_q - 8'd1;
`ifdef LIVES_BLINK_EN
                        blink_d = blink_q + 1'b1;
`endif
                        if (timer_q == 8'd1) begin
                            state_d = ALIVE;
                        end else begin
                            state_d = INVULN;
                        end
                    end else begin
                        state_d = INVULN;
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                default: begin
                    state_d = ALIVE;
                    lives_d = INIT_L;
                    timer_d = 8'd0;
                end
            endcase
        end
    end

    assign x12_s     = {1'b0, pixelX};
    assign y12_s     = {1'b0, pixelY};
    assign right_x_s = TLX12 + ({9'd0, lives_q} << TILE_BITS);

    // Rectangle hit test and offsets, computed 12 bits wide so edges never wrap.
    always_comb begin
        inside_d = 1'b0;
        offx_d   = 11'd0;
        offy_d   = 11'd0;
        if ((x12_s >= TLX12) && (x12_s < right_x_s) &&
            (y12_s >= TLY12) && (y12_s < (TLY12 + TILE12))) begin
            inside_d = 1'b1;
            offx_d   = 11'(x12_s - TLX12);
            offy_d   = 11'(y12_s - TLY12);
        end else begin
            inside_d = 1'b0;
        end
`ifdef LIVES_BLINK_EN
        if ((state_q == INVULN) && blink_q[BLINK_LOG2]) begin
            inside_d = 1'b0;
            offx_d   = 11'd0;
            offy_d   = 11'd0;
        end else begin
            inside_d = inside_d;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ALIVE;
            lives_q     <= INIT_L;
            timer_q     <= 8'd0;
            game_over_q <= 1'b0;
            inside_q    <= 1'b0;
            offx_q      <= 11'd0;
            offy_q      <= 11'd0;
`ifdef LIVES_BLINK_EN
            blink_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            game_over_q <= (state_d == DEAD);
            inside_q    <= inside_d;
            offx_q      <= offx_d;
            offy_q      <= offy_d;
`ifdef LIVES_BLINK_EN
            blink_q     <= blink_d;
`endif
        end
    end

    assign InsideRectangle = inside_q;
    assign offsetX         = offx_q;
    assign offsetY         = offy_q;
    assign livesCount      = lives_q;
    assign gameOver        = game_over_q;

endmodule

// File: tb/tb_lives_hud_ctrl.sv
// Self-checking bench for lives_hud_ctrl: pixel expectations go through a scoreboard queue.
module tb_lives_hud_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;
    logic        startOfFrame = 1'b0;
    logic        hit = 1'b0;
    logic        extraLife = 1'b0;
    logic        newGame = 1'b0;
    logic        InsideRectangle;
    logic [10:0] offsetX, offsetY;
    logic [2:0]  livesCount;
    logic        gameOver;

    int checks = 0;
    int errors = 0;
    int m_lives = 3;

    logic [22:0] sb_q[$];
    logic [22:0] exp_v;
    logic [22:0] got_v;

    lives_hud_ctrl dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .hit(hit), .extraLife(extraLife), .newGame(newGame),
        .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
        .livesCount(livesCount), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel, queue the independently-derived expectation, compare one cycle later.
    task automatic scan(input int x, input int y, input bit hidden, input string tag);
        bit in_s;
        pixelX = 11'(x);
        pixelY = 11'(y);
        in_s = !hidden && (m_lives > 0) && (x >= 16) && (x < 16 + 32 * m_lives) && (y >= 8) && (y < 40);
        sb_q.push_back(in_s ? {1'b1, 11'(x - 16), 11'(y - 8)} : 23'd0);
        tick();
        exp_v = sb_q.pop_front();
        got_v = {InsideRectangle, offsetX, offsetY};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got ins=%0b ox=%0d oy=%0d want ins=%0b ox=%0d oy=%0d", tag,
                     got_v[22], got_v[21:11], got_v[10:0], exp_v[22], exp_v[21:11], exp_v[10:0]);
        end
    endtask

    task automatic sof_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
    endtask

    task automatic pulse_xl();
        extraLife = 1'b1;
        tick();
        extraLife = 1'b0;
        tick();
    endtask

    task automatic check_lives(input int want_l, input bit want_go, input string tag);
        checks++;
        if (livesCount !== 3'(want_l) || gameOver !== want_go) begin
            errors++;
            $display("FAIL %s: got lives=%0d go=%0b want lives=%0d go=%0b", tag, livesCount, gameOver, want_l, want_go);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #12;
        checks++;
        if (livesCount !== 3'd3 || gameOver !== 1'b0 || InsideRectangle !== 1'b0 ||
            offsetX !== 11'd0 || offsetY !== 11'd0) begin
            errors++;
            $display("FAIL reset: got lives=%0d go=%0b ins=%0b ox=%0d oy=%0d want 3 0 0 0 0",
                     livesCount, gameOver, InsideRectangle, offsetX, offsetY);
        end
        @(negedge clk);
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_geometry();
        scan(16, 8, 1'b0, "geom_origin");
        scan(111, 39, 1'b0, "geom_far_corner");
        scan(112, 8, 1'b0, "geom_right_edge");
        scan(15, 8, 1'b0, "geom_left_edge");
        scan(16, 40, 1'b0, "geom_bottom_edge");
        scan(50, 7, 1'b0, "geom_top_edge");
    endtask

    task automatic test_hit_held();
        hit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_lives(2, 1'b0, "hit_held_once");
        end
        hit = 1'b0;
        tick();
        m_lives = 2;
        sof_pulses(119);
        pulse_hit();
        check_lives(2, 1'b0, "hit_ignored_invuln");
        sof_pulses(1);
        pulse_hit();
        check_lives(1, 1'b0, "hit_after_invuln");
        m_lives = 1;
        sof_pulses(120);
        pulse_hit();
        check_lives(0, 1'b1, "hit_fatal");
        m_lives = 0;
        scan(16, 8, 1'b0, "dead_no_hearts");
        pulse_xl();
        check_lives(0, 1'b1, "dead_ignores_extra");
    endtask

    task automatic test_newgame();
        newGame = 1'b1;
        hit = 1'b1;
        tick();
        newGame = 1'b0;
        check_lives(3, 1'b0, "newgame_beats_hit");
        tick();
        tick();
        hit = 1'b0;
        tick();
        check_lives(3, 1'b0, "newgame_hit_consumed");
        m_lives = 3;
    endtask

    task automatic test_extra_sat();
        for (int i = 0; i < 4; i++) begin
            pulse_xl();
            check_lives((i < 2) ? 4 + i : 5, 1'b0, "extra_saturate");
        end
        m_lives = 5;
        scan(175, 20, 1'b0, "geom_five_last");
        scan(176, 20, 1'b0, "geom_five_past");
    endtask

    task automatic test_hit_extra_same();
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        pulse_hit();
        sof_pulses(120);
        pulse_hit();
        sof_pulses(120);
        check_lives(1, 1'b0, "setup_one_life");
        m_lives = 1;
        hit = 1'b1;
        extraLife = 1'b1;
        tick();
        hit = 1'b0;
        extraLife = 1'b0;
        tick();
        check_lives(1, 1'b0, "hit_extra_same");
    endtask

    task automatic test_blink();
        for (int f = 0; f < 16; f++) begin
`ifdef LIVES_BLINK_EN
            scan(16, 8, (f >= 8), "blink_frame");
`else
            scan(16, 8, 1'b0, "steady_frame");
`endif
            sof_pulses(1);
        end
        pulse_hit();
        check_lives(1, 1'b0, "invuln_after_same_cycle");
    endtask

    task automatic test_reset_mid();
        pulse_xl();
        check_lives(2, 1'b0, "extra_in_invuln");
        m_lives = 2;
        scan(20, 10, 1'b0, "pre_reset_pixel");
        resetN = 1'b0;
        #1;
        checks++;
        if (livesCount !== 3'd3 || gameOver !== 1'b0 || InsideRectangle !== 1'b0 ||
            offsetX !== 11'd0 || offsetY !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got lives=%0d go=%0b ins=%0b ox=%0d oy=%0d want 3 0 0 0 0",
                     livesCount, gameOver, InsideRectangle, offsetX, offsetY);
        end
        @(negedge clk);
        resetN = 1'b1;
        tick();
        m_lives = 3;
        pulse_hit();
        check_lives(2, 1'b0, "alive_after_reset");
    endtask

    initial begin
        test_reset();
        test_geometry();
        test_hit_held();
        test_newgame();
        test_extra_sat();
        test_hit_extra_same();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
